// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch opcodes, branch FSM states, condition decode.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_JMP  = 3'b000,
    OP_JC   = 3'b001,
    OP_JNC  = 3'b010,
    OP_JZ   = 3'b011,
    OP_JNZ  = 3'b100,
    OP_JS   = 3'b101,
    OP_CALL = 3'b110,
    OP_RET  = 3'b111
  } branch_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    POP   = 2'd3
  } br_state_t;

  // Flag condition for the conditional jumps. CALL and RET depend on the
  // stack, not on flags, so they are not decided here.
  function automatic logic cond_met(input branch_op_t op, input logic cy,
                                    input logic z, input logic s);
    logic met;
    met = 1'b0;
    case (op)
      OP_JMP:  met = 1'b1;
      OP_JC:   met = cy;
      OP_JNC:  met = ~cy;
      OP_JZ:   met = z;
      OP_JNZ:  met = ~z;
      OP_JS:   met = s;
      default: met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Hardware return stack (LIFO). The pointer saturates at 0 and DEPTH, so a
// push when full or a pop when empty leaves the stack unchanged.
module ret_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  // ptr points at the next free slot; the top of stack is one below it.
  // At ptr=DEPTH the low bits wrap to 0, so rd_idx still lands on DEPTH-1.
  assign wr_idx = ptr_q[IW-1:0];
  assign rd_idx = wr_idx - IW'(1);
  assign full   = (ptr_q == PW'(DEPTH));
  assign empty  = (ptr_q == '0);
  assign dout   = empty ? '0 : mem_q[rd_idx];

  // Push has priority; the controller never requests both at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !full) begin
      mem_q[wr_idx] <= din;
      ptr_q         <= ptr_q + PW'(1);
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - PW'(1);
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch / CALL / RET control unit. Snapshots opcode, flags and return PC at
// START, fetches the target operand, then loads or falls through.
//
//   state | meaning
//   IDLE  | waiting for START
//   FETCH | MEM_REQ high, waiting for the target operand
//   EXEC  | DONE; PC_LOAD if taken, CALL pushes the return PC
//   POP   | DONE; PC_LOAD with popped address if the stack was non-empty
module branch_ctrl
  import cpu_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [2:0]    OP,
  input  logic          CY,
  input  logic          Z,
  input  logic          S,
  input  logic [AW-1:0] PC,
  input  logic [AW-1:0] MEM_DATA,
  input  logic          MEM_VALID,
  output logic          MEM_REQ,
  output logic          PC_LOAD,
  output logic [AW-1:0] PC_NEXT,
  output logic          BUSY,
  output logic          DONE,
  output logic          STK_ERR
);

  br_state_t     state_q;
  branch_op_t    op_q;
  logic          cy_q, z_q, s_q;
  logic [AW-1:0] pc_q;

  logic          mem_req_q, pc_load_q, busy_q, done_q, stk_err_q;
  logic [AW-1:0] pc_next_q;

  logic          stk_push, stk_pop, stk_full, stk_empty;
  logic [AW-1:0] stk_dout;
  logic          taken_d;

  // Outcome of the snapshotted instruction; stable for the whole FETCH.
  always_comb begin
    taken_d = 1'b0;
    if (op_q == OP_CALL) taken_d = ~stk_full;
    else                 taken_d = cond_met(op_q, cy_q, z_q, s_q);
  end

  // Stack moves on the edge that leaves EXEC/POP, so IDLE always sees it settled.
  assign stk_push = (state_q == EXEC) && (op_q == OP_CALL) && pc_load_q;
  assign stk_pop  = (state_q == POP) && pc_load_q;

  ret_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
    .CLK   (CLK),
    .RST   (RST),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_q),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // FSM, snapshots and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      op_q      <= OP_JMP;
      cy_q      <= 1'b0;
      z_q       <= 1'b0;
      s_q       <= 1'b0;
      pc_q      <= '0;
      mem_req_q <= 1'b0;
      pc_load_q <= 1'b0;
      pc_next_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      stk_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            op_q   <= branch_op_t'(OP);
            cy_q   <= CY;
            z_q    <= Z;
            s_q    <= S;
            pc_q   <= PC;
            busy_q <= 1'b1;
            if (branch_op_t'(OP) == OP_RET) begin
              state_q   <= POP;
              done_q    <= 1'b1;
              pc_load_q <= ~stk_empty;
              pc_next_q <= stk_dout;
              if (stk_empty) stk_err_q <= 1'b1;
            end else begin
              state_q   <= FETCH;
              mem_req_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (MEM_VALID) begin
            state_q   <= EXEC;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            pc_load_q <= taken_d;
            pc_next_q <= taken_d ? MEM_DATA : '0;
            if (op_q == OP_CALL && stk_full) stk_err_q <= 1'b1;
          end
        end
        EXEC, POP: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          pc_load_q <= 1'b0;
          pc_next_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MEM_REQ = mem_req_q;
  assign PC_LOAD = pc_load_q;
  assign PC_NEXT = pc_next_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign STK_ERR = stk_err_q;

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Control-flow unit for the 8-bit CPU. It is the consumer of the CY/Z/S flag register. On a decoded branch instruction it fetches the target-address operand from program memory and evaluates the condition against the registered flags. It then either loads the program counter or lets execution fall through, and it keeps a small hardware return stack for CALL/RET.

## Interface
Parameters:
- AW, 8, program-address and operand width.
- DEPTH, 4, return-stack entries (power of two, ≥2).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle pulse: branch instruction decoded. Ignored while BUSY=1.
- OP  in  3  kind, sampled with START: 000 JMP, 001 JC, 010 JNC, 011 JZ, 100 JNZ, 101 JS, 110 CALL, 111 RET.
- CY, Z, S  in  1 each  flags from the flag register, sampled with START.
- PC  in  AW  address of the instruction following the operand (return address), sampled with START.
- MEM_DATA  in  AW  operand from program memory; valid when MEM_VALID=1.
- MEM_VALID  in  1  operand handshake from program memory.
- MEM_REQ  out  1  operand request; held high in FETCH.
- PC_LOAD  out  1  one-cycle pulse: load PC_NEXT into the program counter.
- PC_NEXT  out  AW  new program-counter value; meaningful only when PC_LOAD=1, otherwise 0.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse: instruction complete.
- STK_ERR  out  1  sticky: stack overflow or underflow occurred.

## Operation
- States: IDLE, FETCH, EXEC, POP.
- IDLE:
  - On START, latch OP, CY/Z/S and PC into snapshot registers.
  - OP=RET goes to POP; any other OP goes to FETCH.
- FETCH:
  - MEM_REQ=1.
  - On MEM_VALID=1, latch MEM_DATA as the target and go to EXEC.
  - Stays in FETCH indefinitely without MEM_VALID.
- EXEC (one cycle, DONE=1, then IDLE). Taken condition uses the snapshot flags, never the live ones:
  - JMP: always taken.
  - JC: CY=1. JNC: CY=0.
  - JZ: Z=1. JNZ: Z=0.
  - JS: S=1.
  - CALL: taken when the stack is not full; the snapshot PC is pushed in the same cycle.
- Taken: PC_LOAD=1 and PC_NEXT=target.
- Not taken: PC_LOAD=0. The operand is still consumed.
- CALL with the stack full: no push, PC_LOAD=0, STK_ERR set.
- POP (one cycle, DONE=1, then IDLE):
  - Stack non-empty: pop, PC_LOAD=1, PC_NEXT=popped value.
  - Stack empty: PC_LOAD=0, STK_ERR set.
- Stack pointer counts 0..DEPTH. Full when ptr=DEPTH, empty when ptr=0. The pointer never wraps.
- STK_ERR clears only on RST.

## Timing
- Reset values: state IDLE, stack pointer 0, stack contents 0. Outputs MEM_REQ, PC_LOAD, PC_NEXT, BUSY, DONE and STK_ERR are all 0.
- Outputs are Moore, decoded from state and registers. There is no combinational path from the inputs to the outputs.
- Jump/CALL latency:
  - START at cycle t gives MEM_REQ from t+1.
  - MEM_VALID at cycle f gives DONE/PC_LOAD at f+1.
  - Minimum is DONE at t+2.
- RET latency: START at t gives DONE/PC_LOAD at t+1.
- Back-to-back: a new START is accepted in the cycle after DONE, when the state is IDLE again.
- START while BUSY: dropped, with no effect on state or snapshots.
- MEM_VALID outside FETCH: ignored.
- Flag changes after START do not affect the outcome of that instruction.
- RST mid-operation (any state): immediately returns to IDLE. The stack is emptied, STK_ERR is cleared, and no PC_LOAD or DONE is issued.

## Structure
- The shared package cpu_pkg holds:
  - branch_op_t, the 3-bit enum for the OP codes.
  - br_state_t, the enum {IDLE, FETCH, EXEC, POP}.
- Sub-module ret_stack: parameterised LIFO (AW, DEPTH).
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty.
  - Same CLK and RST as the parent.
- branch_ctrl contains the FSM, the snapshot registers and the condition decode.

## Test plan
- Reset: assert RST in FETCH → next cycle BUSY=0, MEM_REQ=0, STK_ERR=0. A following RET produces STK_ERR=1 (stack empty).
- JZ with Z=1:
  - Stimulus: START at t, OP=011, Z=1, MEM_VALID at t+3 with MEM_DATA=0x42.
  - Required: MEM_REQ high t+1..t+3, then DONE=1, PC_LOAD=1 and PC_NEXT=0x42 at t+4.
- JNC with CY=1 at START, CY dropping to 0 on the next cycle → not taken: DONE=1, PC_LOAD=0.
- CALL then RET:
  - Stimulus: CALL with PC=0x10, target 0x80, then RET.
  - Required: first PC_NEXT=0x80, then the RET's PC_NEXT=0x10 at t+1 after its START.
- Overflow: five CALLs (DEPTH=4) → the fifth has PC_LOAD=0 and STK_ERR=1. Four RETs then return the four pushed addresses in LIFO order.
- START pulsed during FETCH with a different OP → ignored; the original instruction completes unchanged.
